mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Initiator-side load/store unit for the MIPS datapath.
- Takes byte, halfword and word load/store requests from the pipeline over a valid/ready handshake and drives the word-wide byte-addressed memory port (write, addr, wdata, rdata).
- Memory is big-endian: the byte at offset 0 maps to bits [31:24]. Reads have one cycle of registered latency.
- Sub-word stores are done as read-modify-write of the enclosing aligned word. Loads are extracted and sign- or zero-extended.

Parameters:
- ADDR_W, 32, width of the request and memory address buses.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept; high only in IDLE.
- req_write  in  1  0 = load, 1 = store.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; holds its value until the next load completes.
- resp_err  out  1  misaligned request; qualified by resp_valid. Tied 0 without the optional feature.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  word-aligned address; bits [1:0] are always 00.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid the cycle after the address is presented with mem_write low.

Behaviour:
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_write 0, mem_addr 0, mem_wdata 0.
- Memory-side outputs are decoded only from registered state and registers. There is no combinational path from req_* to mem_*.
- Handshake: a request is accepted on the edge where req_valid && req_ready. Opcode, address and data are latched on that edge. req_* inputs are don't-care outside the handshake.
- States: IDLE, RD, CAP, WR, RESP.
- IDLE: on accept, sw goes to WR; every other request goes to RD.
- RD: mem_addr = {addr[ADDR_W-1:2],00}, mem_write 0. Next state is CAP.
- CAP, load: select the lane, extend into resp_rdata, then RESP.
- CAP, sb/sh: merge the store lane into mem_rdata and register the result into the write-data register, then WR.
- WR: mem_write 1 for exactly one cycle, with mem_addr and mem_wdata stable for that whole cycle. Next state is RESP.
- RESP: resp_valid 1 for one cycle, req_ready 0, then IDLE.
- Latency, counting the accept edge as the start of cycle 1:
  - lw, lb, lbu, lh, lhu: RD in cycle 1, CAP in cycle 2, resp_valid in cycle 3.
  - sw: WR in cycle 1, resp_valid in cycle 2.
  - sb, sh: RD 1, CAP 2, WR 3, resp_valid in cycle 4.
- Back-to-back requests: the next request is accepted in the IDLE cycle after RESP. No overlap.
- Lane select, byte: offset 0 is [31:24], 1 is [23:16], 2 is [15:8], 3 is [7:0].
- Lane select, half: addr[1] = 0 selects [31:16]; addr[1] = 1 selects [15:0].
- Extension: sign-extend from the lane MSB unless req_unsigned is set. req_unsigned is ignored for word loads and for all stores.
- Store data: only req_wdata[7:0] (byte) or [15:0] (half) is used. The other lanes of the read word are preserved unchanged.
- Without the optional feature, misaligned halfword addresses ignore addr[0] and misaligned word addresses ignore addr[1:0].
- Reset mid-operation forces IDLE asynchronously and drops mem_write at once. A partially completed RMW never writes; memory is left untouched. No resp_valid is produced for the aborted request.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a half request with addr[0] = 1, or a word request with addr[1:0] != 00, issues no memory access. It goes IDLE -> RESP, giving resp_valid with resp_err = 1 in cycle 1. resp_rdata is unchanged and mem_write stays 0 throughout.
- Undefined: resp_err is tied 0 and misaligned requests are aligned as described under Behaviour.

Test Plan:
- sw 0x10 = 0x8899AABB, then lw 0x10 -> resp_rdata 0x8899AABB in cycle 3; sw resp_valid in cycle 2; exactly one mem_write cycle.
- On word 0x8899AABB at 0x10: lb 0x11 -> 0xFFFFFF99; lbu 0x11 -> 0x00000099; lh 0x12 -> 0xFFFFAABB; lhu 0x10 -> 0x00008899.
- sb 0x13 with wdata 0x123456CC -> word becomes 0x8899AACC, resp_valid in cycle 4. Then sh 0x10 with wdata 0xFFFF1234 -> lw 0x10 returns 0x1234AACC.
- sb in progress with rst pulsed during CAP -> mem_write never asserted, lw 0x10 after reset returns the old word, all outputs at reset values.
- Misaligned lw 0x12: with MISALIGN_TRAP_EN, resp_err 1 in cycle 1 and no memory access. Without it, returns the word at 0x10 with resp_err 0.
- req_valid held high for three consecutive lw requests -> accepts spaced 4 cycles apart; req_ready low in RD, CAP and RESP.

Source files
------------

// File: rtl/mem_access_if.sv
// Load/store unit bus bundle: pipeline request/response handshake plus word-wide memory port.
// slave = load/store unit view, master = pipeline/memory environment view.
interface mem_access_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access.sv
// MIPS load/store unit: byte/half/word access to a big-endian word memory, RMW for sub-word stores.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word requests complete immediately with resp_err.
module mem_access #(
    parameter int unsigned ADDR_W = 32
) (
    input logic          clk,
    input logic          rst,
    mem_access_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t              state, state_n;
    logic                op_write, op_write_n;
    logic [1:0]          op_size, op_size_n;
    logic                op_unsigned, op_unsigned_n;
    logic [1:0]          op_off, op_off_n;
    logic [HALF_W-1:0]   op_wdata, op_wdata_n;
    logic [ADDR_W-1:0]   mem_addr_n;
    logic [DATA_W-1:0]   mem_wdata_n;
    logic [DATA_W-1:0]   resp_rdata_n;
    logic                resp_err_n;
    logic                misalign_c;
    logic [BYTE_W-1:0]   lane_b_c;
    logic [HALF_W-1:0]   lane_h_c;
    logic [DATA_W-1:0]   load_c;
    logic [DATA_W-1:0]   merge_c;

`ifdef MISALIGN_TRAP_EN
    assign misalign_c = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                        (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    // Lane extraction from the returned word; offset 0 is the most significant byte.
    always_comb begin
        lane_b_c = bus.mem_rdata[31:24];
        case (op_off)
            2'd0:    lane_b_c = bus.mem_rdata[31:24];
            2'd1:    lane_b_c = bus.mem_rdata[23:16];
            2'd2:    lane_b_c = bus.mem_rdata[15:8];
            default: lane_b_c = bus.mem_rdata[7:0];
        endcase
        lane_h_c = op_off[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
    end

    always_comb begin
        load_c = bus.mem_rdata;
        case (op_size)
            2'b00:   load_c = op_unsigned ? DATA_W'(lane_b_c)
                                          : {{(DATA_W-BYTE_W){lane_b_c[BYTE_W-1]}}, lane_b_c};
            2'b01:   load_c = op_unsigned ? DATA_W'(lane_h_c)
                                          : {{(DATA_W-HALF_W){lane_h_c[HALF_W-1]}}, lane_h_c};
            default: load_c = bus.mem_rdata;
        endcase
    end

    // Store lane merged into the read word; untouched lanes keep their old contents.
    always_comb begin
        merge_c = bus.mem_rdata;
        if (op_size == 2'b00) begin
            case (op_off)
                2'd0:    merge_c = {op_wdata[7:0], bus.mem_rdata[23:0]};
                2'd1:    merge_c = {bus.mem_rdata[31:24], op_wdata[7:0], bus.mem_rdata[15:0]};
                2'd2:    merge_c = {bus.mem_rdata[31:16], op_wdata[7:0], bus.mem_rdata[7:0]};
                default: merge_c = {bus.mem_rdata[31:8], op_wdata[7:0]};
            endcase
        end else begin
            merge_c = op_off[1] ? {bus.mem_rdata[31:16], op_wdata}
                                : {op_wdata, bus.mem_rdata[15:0]};
        end
    end

    // Next-state and next-register decode.
    always_comb begin
        state_n       = state;
        op_write_n    = op_write;
        op_size_n     = op_size;
        op_unsigned_n = op_unsigned;
        op_off_n      = op_off;
        op_wdata_n    = op_wdata;
        mem_addr_n    = bus.mem_addr;
        mem_wdata_n   = bus.mem_wdata;
        resp_rdata_n  = bus.resp_rdata;
        resp_err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    op_write_n    = bus.req_write;
                    op_size_n     = bus.req_size;
                    op_unsigned_n = bus.req_unsigned;
                    op_off_n      = bus.req_addr[1:0];
                    op_wdata_n    = bus.req_wdata[15:0];
                    if (misalign_c) begin
                        state_n    = RESP;
                        resp_err_n = 1'b1;
                    end else begin
                        mem_addr_n = {bus.req_addr[ADDR_W-1:2], 2'b00};
                        if (bus.req_write && bus.req_size[1]) begin
                            mem_wdata_n = bus.req_wdata;
                            state_n     = WR;
                        end else begin
                            state_n = RD;
                        end
                    end
                end
            end
            RD:  state_n = CAP;
            CAP: begin
                if (op_write) begin
                    mem_wdata_n = merge_c;
                    state_n     = WR;
                end else begin
                    resp_rdata_n = load_c;
                    state_n      = RESP;
                end
            end
            WR:      state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; strobes are decoded from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            op_write       <= 1'b0;
            op_size        <= 2'b00;
            op_unsigned    <= 1'b0;
            op_off         <= 2'b00;
            op_wdata       <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            bus.mem_write  <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
        end else begin
            state          <= state_n;
            op_write       <= op_write_n;
            op_size        <= op_size_n;
            op_unsigned    <= op_unsigned_n;
            op_off         <= op_off_n;
            op_wdata       <= op_wdata_n;
            bus.req_ready  <= (state_n == IDLE);
            bus.resp_valid <= (state_n == RESP);
            bus.resp_rdata <= resp_rdata_n;
            bus.resp_err   <= resp_err_n;
            bus.mem_write  <= (state_n == WR);
            bus.mem_addr   <= mem_addr_n;
            bus.mem_wdata  <= mem_wdata_n;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, reset/back-to-back sequences,
// and random traffic checked against a byte-array memory model.
module tb_mem_access;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_if #(.ADDR_W(32)) bus ();
    mem_access #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Word memory seen by the DUT: registered read, write on strobe.
    logic [31:0] env_mem [64];
    always @(posedge clk) begin
        if (bus.mem_write) env_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        bus.mem_rdata <= env_mem[bus.mem_addr[7:2]];
    end

    // Reference model: flat big-endian byte array.
    logic [7:0]  ref_mem [256];
    logic [31:0] last_load;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic is_trap(input logic [1:0] sz, input logic [7:0] a);
`ifdef MISALIGN_TRAP_EN
        return ((nbytes(sz) == 2) && a[0]) || ((nbytes(sz) == 4) && (a[1:0] != 2'b00));
`else
        return 1'b0 & sz[0] & a[0];
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic u, input logic [7:0] a);
        int n = nbytes(sz);
        int base = int'(a) & ~(n - 1);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[base + i]);
        if (n < 4 && !u && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] wd);
        int n = nbytes(sz);
        int base = int'(a) & ~(n - 1);
        for (int i = 0; i < n; i++) ref_mem[base + i] = 8'(wd >> (8 * (n - 1 - i)));
    endtask

    function automatic int exp_latency(input logic w, input logic [1:0] sz, input logic trap);
        if (trap) return 1;
        if (!w) return 3;
        return (nbytes(sz) == 4) ? 2 : 4;
    endfunction

    // One request: returns response data/error, cycle of resp_valid (0 = timeout), write-strobe cycles.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u, input logic [7:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat, output int nwr);
        int guard = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
        bus.req_unsigned = u; bus.req_addr = 32'(a); bus.req_wdata = wd;
        while (!bus.req_ready && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0; nwr = 0; rd = 32'h0; er = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            nwr += int'(bus.mem_write);
            if (bus.resp_valid) begin
                lat = c; rd = bus.resp_rdata; er = bus.resp_err;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'h1);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'h0);
        chk({tag, "_resp_rdata"}, bus.resp_rdata, 32'h0);
        chk({tag, "_resp_err"}, 32'(bus.resp_err), 32'h0);
        chk({tag, "_mem_write"}, 32'(bus.mem_write), 32'h0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        int lat, nwr;

        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        for (int i = 0; i < 64; i++) begin
            logic [31:0] word;
            word = $urandom;
            env_mem[i] = word;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = 8'(word >> (8 * (3 - b)));
        end
        last_load = 32'h0;

        //            w     sz     u     addr   wdata          rdata          err  lat wr
        tbl[0]  = '{1'b1, 2'b10, 1'b0, 8'h10, 32'h8899AABB, 32'h00000000, 1'b0, 2, 1};
        tbl[1]  = '{1'b0, 2'b10, 1'b0, 8'h10, 32'h0,        32'h8899AABB, 1'b0, 3, 0};
        tbl[2]  = '{1'b0, 2'b00, 1'b0, 8'h11, 32'h0,        32'hFFFFFF99, 1'b0, 3, 0};
        tbl[3]  = '{1'b0, 2'b00, 1'b1, 8'h11, 32'h0,        32'h00000099, 1'b0, 3, 0};
        tbl[4]  = '{1'b0, 2'b01, 1'b0, 8'h12, 32'h0,        32'hFFFFAABB, 1'b0, 3, 0};
        tbl[5]  = '{1'b0, 2'b01, 1'b1, 8'h10, 32'h0,        32'h00008899, 1'b0, 3, 0};
        tbl[6]  = '{1'b1, 2'b00, 1'b0, 8'h13, 32'h123456CC, 32'h00008899, 1'b0, 4, 1};
        tbl[7]  = '{1'b0, 2'b10, 1'b0, 8'h10, 32'h0,        32'h8899AACC, 1'b0, 3, 0};
        tbl[8]  = '{1'b1, 2'b01, 1'b0, 8'h10, 32'hFFFF1234, 32'h8899AACC, 1'b0, 4, 1};
        tbl[9]  = '{1'b0, 2'b10, 1'b0, 8'h10, 32'h0,        32'h1234AACC, 1'b0, 3, 0};
        tbl[10] = '{1'b0, 2'b00, 1'b0, 8'h10, 32'h0,        32'h00000012, 1'b0, 3, 0};
        tbl[11] = '{1'b0, 2'b01, 1'b0, 8'h12, 32'h0,        32'hFFFFAACC, 1'b0, 3, 0};
`ifdef MISALIGN_TRAP_EN
        tbl[12] = '{1'b0, 2'b10, 1'b0, 8'h12, 32'h0,        32'hFFFFAACC, 1'b1, 1, 0};
`else
        tbl[12] = '{1'b0, 2'b10, 1'b0, 8'h12, 32'h0,        32'h1234AACC, 1'b0, 3, 0};
`endif
        tbl[13] = '{1'b0, 2'b11, 1'b1, 8'h10, 32'h0,        32'h1234AACC, 1'b0, 3, 0};
        tbl[14] = '{1'b0, 2'b00, 1'b1, 8'h12, 32'h0,        32'h000000AA, 1'b0, 3, 0};
`ifdef MISALIGN_TRAP_EN
        tbl[15] = '{1'b0, 2'b01, 1'b0, 8'h13, 32'h0,        32'h000000AA, 1'b1, 1, 0};
`else
        tbl[15] = '{1'b0, 2'b01, 1'b0, 8'h13, 32'h0,        32'hFFFFAACC, 1'b0, 3, 0};
`endif

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            do_req(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].addr, tbl[i].wdata, rd, er, lat, nwr);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
            chk($sformatf("vec%0d_writes", i), 32'(nwr), 32'(tbl[i].exp_wr));
            if (tbl[i].w && !tbl[i].exp_err) ref_store(tbl[i].sz, tbl[i].addr, tbl[i].wdata);
            last_load = tbl[i].exp_rdata;
        end

        // Reset pulsed while an sb sits in CAP: nothing written, no response.
        begin
            int wcnt = 0;
            int rcnt = 0;
            @(negedge clk);
            bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
            bus.req_unsigned = 1'b0; bus.req_addr = 32'h13; bus.req_wdata = 32'h000000EE;
            @(posedge clk);
            #1 bus.req_valid = 1'b0;
            @(negedge clk);
            wcnt += int'(bus.mem_write); rcnt += int'(bus.resp_valid);
            @(negedge clk);
            wcnt += int'(bus.mem_write); rcnt += int'(bus.resp_valid);
            rst = 1'b1;
            #1;
            check_reset_outputs("midrst");
            @(negedge clk);
            rst = 1'b0;
            repeat (4) begin
                @(negedge clk);
                wcnt += int'(bus.mem_write); rcnt += int'(bus.resp_valid);
            end
            chk("midrst_no_write", 32'(wcnt), 32'h0);
            chk("midrst_no_resp", 32'(rcnt), 32'h0);
            last_load = 32'h0;
            do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, rd, er, lat, nwr);
            chk("midrst_lw_old_word", rd, ref_load(2'b10, 1'b0, 8'h10));
            chk("midrst_lw_latency", 32'(lat), 32'd3);
            last_load = rd;
        end

        // req_valid held for three lw: accepts spaced 4 cycles, ready low in RD/CAP/RESP.
        begin
            int acc [3] = '{-100, -100, -100};
            int accepts = 0;
            int k = 0;
            int low = 0;
            int rv = 0;
            logic [31:0] last_rd = 32'h0;
            @(negedge clk);
            bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
            bus.req_unsigned = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
            while (accepts < 3 && k < 40) begin
                if (bus.resp_valid) rv++;
                if (bus.req_ready) begin
                    acc[accepts] = k;
                    accepts++;
                end else begin
                    low++;
                end
                if (accepts == 3) begin
                    @(posedge clk);
                    #1 bus.req_valid = 1'b0;
                end else begin
                    @(negedge clk);
                    k++;
                end
            end
            bus.req_valid = 1'b0;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (bus.resp_valid) begin
                    rv++;
                    last_rd = bus.resp_rdata;
                    break;
                end
            end
            chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd4);
            chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd4);
            chk("b2b_ready_low", 32'(low), 32'd6);
            chk("b2b_responses", 32'(rv), 32'd3);
            chk("b2b_rdata", last_rd, ref_load(2'b10, 1'b0, 8'h10));
            last_load = ref_load(2'b10, 1'b0, 8'h10);
        end

        // Random traffic against the byte-array model.
        for (int i = 0; i < 150; i++) begin
            logic        w, u, trap;
            logic [1:0]  sz;
            logic [7:0]  a;
            logic [31:0] wd, exp_rd;
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = 8'($urandom_range(0, 255));
            wd = $urandom;
            trap = is_trap(sz, a);
            do_req(w, sz, u, a, wd, rd, er, lat, nwr);
            if (!w && !trap) last_load = ref_load(sz, u, a);
            exp_rd = last_load;
            if (w && !trap) ref_store(sz, a, wd);
            chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
            chk($sformatf("rnd%0d_err", i), 32'(er), 32'(trap));
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(exp_latency(w, sz, trap)));
            chk($sformatf("rnd%0d_writes", i), 32'(nwr), (w && !trap) ? 32'd1 : 32'd0);
        end

        // Memory contents must match the model word for word.
        for (int i = 0; i < 64; i++)
            chk($sformatf("final_mem%0d", i), env_mem[i],
                {ref_mem[4*i], ref_mem[4*i+1], ref_mem[4*i+2], ref_mem[4*i+3]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
